// File: rtl/rggen_rtl_pkg.sv
// Shared rggen RTL types: opcodes for the bit-field initiator command channel.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_INIT_READ      = 2'd0,
        RGGEN_INIT_WRITE     = 2'd1,
        RGGEN_INIT_RMW_SET   = 2'd2,
        RGGEN_INIT_RMW_CLEAR = 2'd3
    } rggen_initiator_op;

endpackage

// File: rtl/rggen_bit_field_if.sv
// Single bit-field access interface: strobes, mask and write data in; read data and live value out.
interface rggen_bit_field_if #(
    parameter int WIDTH = 32
);
    logic             read_valid;
    logic             write_valid;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] value;

    modport master (
        output read_valid,
        output write_valid,
        output mask,
        output write_data,
        input  read_data,
        input  value
    );

    modport slave (
        input  read_valid,
        input  write_valid,
        input  mask,
        input  write_data,
        output read_data,
        output value
    );
endinterface

// File: rtl/rggen_bit_field_initiator.sv
// Command-driven initiator for one bit field: READ / WRITE / RMW_SET / RMW_CLEAR via single-cycle strobes.
// Latency accept->rsp_valid: error 1, READ/WRITE 2, RMW 3 cycles.
// Backpressure: rsp held in RESP until i_rsp_ready; RGGEN_BIT_FIELD_INITIATOR_RSP_BYPASS_EN accepts in the handshake cycle.
module rggen_bit_field_initiator
    import rggen_rtl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  rggen_initiator_op i_cmd_op,
    input  logic [WIDTH-1:0]  i_cmd_mask,
    input  logic [WIDTH-1:0]  i_cmd_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [WIDTH-1:0]  o_rsp_data,
    output logic              o_rsp_error,
    rggen_bit_field_if.master bit_field_if
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_SAMPLE,
        ST_WRITE,
        ST_RESP
    } state_e;

    state_e            state_q;
    rggen_initiator_op op_q;
    logic [WIDTH-1:0]  mask_q;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH-1:0]  rmw_q;
    logic [WIDTH-1:0]  rsp_data_q;
    logic              read_valid_q;
    logic              write_valid_q;
    logic              rsp_valid_q;
    logic              rsp_error_q;
    logic              cmd_accept;
    logic [WIDTH-1:0]  write_data;

`ifdef RGGEN_BIT_FIELD_INITIATOR_RSP_BYPASS_EN
    assign o_cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && i_rsp_ready);
`else
    assign o_cmd_ready = (state_q == ST_IDLE);
`endif

    assign cmd_accept = i_cmd_valid && o_cmd_ready;

    // Only flop outputs feed this, so write_data is glitch-free and '0 outside the strobe.
    always_comb begin
        write_data = '0;
        if (write_valid_q) begin
            case (op_q)
                RGGEN_INIT_RMW_SET:   write_data = rmw_q | data_q;
                RGGEN_INIT_RMW_CLEAR: write_data = rmw_q & ~data_q;
                default:              write_data = data_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            op_q          <= RGGEN_INIT_READ;
            mask_q        <= '0;
            data_q        <= '0;
            rmw_q         <= '0;
            read_valid_q  <= 1'b0;
            write_valid_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_READ: begin
                    read_valid_q <= 1'b0;
                    rsp_data_q   <= bit_field_if.read_data;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= ST_RESP;
                end
                // Sample the live value without a read strobe so read side effects never fire.
                ST_SAMPLE: begin
                    rmw_q         <= bit_field_if.value;
                    write_valid_q <= 1'b1;
                    state_q       <= ST_WRITE;
                end
                ST_WRITE: begin
                    write_valid_q <= 1'b0;
                    rsp_data_q    <= (op_q == RGGEN_INIT_WRITE) ? '0 : write_data;
                    rsp_valid_q   <= 1'b1;
                    state_q       <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_error_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: ;
            endcase

            // Placed last so an accept in the RESP handshake cycle overrides the return to IDLE.
            if (cmd_accept) begin
                op_q   <= i_cmd_op;
                mask_q <= i_cmd_mask;
                data_q <= i_cmd_data;
                if (i_cmd_mask == '0) begin
                    rsp_valid_q <= 1'b1;
                    rsp_error_q <= 1'b1;
                    rsp_data_q  <= '0;
                    state_q     <= ST_RESP;
                end else begin
                    case (i_cmd_op)
                        RGGEN_INIT_READ: begin
                            read_valid_q <= 1'b1;
                            state_q      <= ST_READ;
                        end
                        RGGEN_INIT_WRITE: begin
                            write_valid_q <= 1'b1;
                            state_q       <= ST_WRITE;
                        end
                        default: state_q <= ST_SAMPLE;
                    endcase
                end
            end
        end
    end

    assign bit_field_if.read_valid  = read_valid_q;
    assign bit_field_if.write_valid = write_valid_q;
    assign bit_field_if.mask        = (read_valid_q || write_valid_q) ? mask_q : '0;
    assign bit_field_if.write_data  = write_data;

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_error = rsp_error_q;

endmodule
